lsu_cache_arbiter: RTL

//  Shares one iob-cache-style native port (valid/addr/wdata/wstrb/rdata/ready)

---
 rtl/lsu_cache_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/lsu_cache_arbiter.sv
// Round-robin arbiter sharing one native cache port between the LSU load and
// store channels, with registered outputs and a sticky cache-stall timeout.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   load_req/addr               load request (level) and address
//   load_data, load_complete    read data (held) and 1-cycle completion pulse
//   store_req/addr/data         store request (level), address and data
//   store_complete              1-cycle completion pulse
//   cache_valid/addr/wdata      native port request side
//   cache_wstrb                 all ones for a store, zero for a load
//   cache_rdata, cache_ready    native port response side
//   busy                        an access is in flight
//   timeout_err                 sticky, set when an access is aborted
module lsu_cache_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_req,
    input  logic [ADDR_W-1:0]   load_addr,
    output logic [DATA_W-1:0]   load_data,
    output logic                load_complete,
    input  logic                store_req,
    input  logic [ADDR_W-1:0]   store_addr,
    input  logic [DATA_W-1:0]   store_data,
    output logic                store_complete,
    output logic                cache_valid,
    output logic [ADDR_W-1:0]   cache_addr,
    output logic [DATA_W-1:0]   cache_wdata,
    output logic [DATA_W/8-1:0] cache_wstrb,
    input  logic [DATA_W-1:0]   cache_rdata,
    input  logic                cache_ready,
    output logic                busy,
    output logic                timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE
    } state_t;

    state_t           state;
    logic             last_load;
    logic [CNT_W-1:0] cnt;

    logic load_cand;
    logic store_cand;
    logic grant_load;
    logic grant_store;
    logic expire;

    // A channel completing this cycle still has its req high (the requester
    // drops it one cycle later), so it is masked to avoid a duplicate grant.
    assign load_cand   = load_req & ~load_complete;
    assign store_cand  = store_req & ~store_complete;
    assign grant_load  = load_cand & (~store_cand | ~last_load);
    assign grant_store = store_cand & (~load_cand | last_load);

    // A ready on the expiry cycle takes priority over the abort.
    assign expire = (TIMEOUT_CYC != 0) && !cache_ready && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            last_load      <= 1'b0;
            cnt            <= '0;
            load_data      <= '0;
            load_complete  <= 1'b0;
            store_complete <= 1'b0;
            cache_valid    <= 1'b0;
            cache_addr     <= '0;
            cache_wdata    <= '0;
            cache_wstrb    <= '0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            load_complete  <= 1'b0;
            store_complete <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_load) begin
                        state       <= LOAD;
                        busy        <= 1'b1;
                        cache_valid <= 1'b1;
                        cache_addr  <= load_addr;
                        cache_wstrb <= '0;
                        last_load   <= 1'b1;
                    end else if (grant_store) begin
                        state       <= STORE;
                        busy        <= 1'b1;
                        cache_valid <= 1'b1;
                        cache_addr  <= store_addr;
                        cache_wdata <= store_data;
                        cache_wstrb <= '1;
                        last_load   <= 1'b0;
                    end
                end
                LOAD, STORE: begin
                    if (cache_ready || expire) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        cache_valid <= 1'b0;
                        cnt         <= '0;
                        if (state == LOAD) begin
                            load_complete <= 1'b1;
                            load_data     <= cache_ready ? cache_rdata : '0;
                        end else begin
                            store_complete <= 1'b1;
                        end
                        if (!cache_ready) begin
                            timeout_err <= 1'b1;
                        end
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
